// File: rtl/fp_mul_scheduler.sv
// Round-robin arbiter sharing one FP32 multiplier among N requesters; operands held HOLD cycles.
// Response after HOLD+1 cycles; rsp port stalls indefinitely, no new grant until the response handshakes.
module fp_mul_scheduler #(
  parameter int N    = 4,
  parameter int IDW  = 2,
  parameter int HOLD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic [2:0]        rsp_exc,
  output logic              busy,
  output logic [15:0]       op_count
);

  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     op_a_q, op_b_q;
  logic [31:0]     rsp_data_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [2:0]      rsp_exc_q;
  logic [15:0]     op_count_q;

  logic            found;
  logic [IDW-1:0]  win;
  logic [31:0]     win_a, win_b;
  logic [IDW-1:0]  ptr_d;

  // {nan, inf, zero} of an IEEE-754 single
  function automatic logic [2:0] classify(input logic [31:0] x);
    logic exp_ones;
    exp_ones = (x[30:23] == 8'hFF);
    return {exp_ones && (x[22:0] != 23'd0),
            exp_ones && (x[22:0] == 23'd0),
            (x[30:0] == 31'd0)};
  endfunction

  // First valid requester at or after ptr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    win   = '0;
    win_a = '0;
    win_b = '0;
    for (int k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
        win_a = req_a[idx*32 +: 32];
        win_b = req_b[idx*32 +: 32];
      end
    end
  end

  always_comb begin
    ptr_d = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
  end

  // Gated by rst_n so every output reads zero while reset is held
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && found) begin
      req_ready = N'(1) << win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_exc_q  <= '0;
      op_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            op_a_q   <= win_a;
            op_b_q   <= win_b;
            rsp_id_q <= win;
            ptr_q    <= ptr_d;
            cnt_q    <= '0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(HOLD - 1)) begin
            rsp_data_q <= mul_out;
            rsp_exc_q  <= classify(mul_out);
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            op_count_q <= op_count_q + 16'd1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_exc   = rsp_exc_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Bench for fp_mul_scheduler: multiplier stub with one register stage, directed and random ops.
module tb_fp_mul_scheduler;
  localparam int N = 4, IDW = 2, HOLD = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     mul_a, mul_b, mul_out;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_data;
  logic [IDW-1:0]  rsp_id;
  logic [2:0]      rsp_exc;
  logic            busy;
  logic [15:0]     op_count;

  int tests = 0;
  int failed = 0;
  int exp_cnt = 0;

  fp_mul_scheduler #(.N(N), .IDW(IDW), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_exc(rsp_exc), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Truncating single-precision multiply; denormal inputs treated as zero
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return 32'h7FC00000;
    if (a_inf || b_inf) begin
      if (a_zero || b_zero) return 32'h7FC00000;
      return {s, 8'hFF, 23'h0};
    end
    if (a_zero || b_zero) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), m};
  endfunction

  function automatic logic [2:0] exp_exc(input logic [31:0] d);
    logic [7:0] e;
    logic [22:0] f;
    e = d[30:23];
    f = d[22:0];
    return {e == 8'hFF && f != 0, e == 8'hFF && f == 0, e == 0 && f == 0};
  endfunction

  logic [31:0] mul_q;
  always @(posedge clk) mul_q <= fmul(mul_a, mul_b);
  assign mul_out = mul_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_norm();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(70, 184));
    return r;
  endfunction

  // One complete operation on requester idx; bg requesters are raised once the op is accepted
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input logic [N-1:0] bg,
                        output logic [31:0] got_d, output logic [2:0] got_e);
    int w;
    logic [31:0] exp_d;
    exp_d = fmul(a, b);
    got_d = '0;
    got_e = '0;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_valid = N'(1) << idx;
    rsp_ready = 1'b0;
    #1;
    w = 0;
    while (req_ready == '0 && w < 20) begin
      tick();
      w++;
    end
    if (req_ready == '0) begin
      chk("grant_timeout", 32'(req_ready), 32'(N'(1) << idx));
      return;
    end
    chk("grant", 32'(req_ready), 32'(N'(1) << idx));
    tick();
    req_valid = bg;
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    #1;
    for (int c = 1; c <= HOLD; c++) begin
      chk("hold_a", mul_a, a);
      chk("hold_b", mul_b, b);
      chk("no_rsp_yet", 32'(rsp_valid), 0);
      chk("no_grant_issue", 32'(req_ready), 0);
      tick();
      #1;
    end
    rsp_ready = (stall == 0);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_id", 32'(rsp_id), 32'(idx));
    chk("rsp_exc", 32'(rsp_exc), 32'(exp_exc(exp_d)));
    chk("op_count_pre", 32'(op_count), 32'(exp_cnt[15:0]));
    chk("no_grant_resp", 32'(req_ready), 0);
    got_d = rsp_data;
    got_e = rsp_exc;
    for (int s = 1; s <= stall; s++) begin
      tick();
      rsp_ready = (s == stall);
      #1;
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_data", rsp_data, exp_d);
      chk("stall_id", 32'(rsp_id), 32'(idx));
      chk("stall_exc", 32'(rsp_exc), 32'(exp_exc(exp_d)));
      chk("stall_no_grant", 32'(req_ready), 0);
    end
    tick();
    rsp_ready = 1'b0;
    exp_cnt++;
    #1;
    chk("op_count_post", 32'(op_count), 32'(exp_cnt[15:0]));
    chk("rsp_cleared", 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [31:0] d;
    logic [2:0] e;
    logic [31:0] ra [N];
    logic [31:0] rb [N];
    rst_n = 1'b0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    #3;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_rsp_data", rsp_data, 0);
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single op: 2.0 * 3.0 on requester 1
    run_op(1, 32'h40000000, 32'h40400000, 0, '0, d, e);
    chk("single_data", d, 32'h40C00000);
    chk("single_exc", 32'(e), 0);
    chk("single_count", 32'(op_count), 1);

    // Exception classification
    run_op(2, 32'h7F800000, 32'h00000000, 0, '0, d, e);
    chk("exc_nan", 32'(e), 32'h4);
    run_op(3, 32'h7F800000, 32'h3F800000, 1, '0, d, e);
    chk("exc_inf", 32'(e), 32'h2);
    chk("exc_inf_data", d, 32'h7F800000);
    run_op(0, 32'h00000000, 32'hBF800000, 0, '0, d, e);
    chk("exc_zero", 32'(e), 32'h1);
    chk("exc_zero_data", d, 32'h80000000);

    // Backpressure with a competing requester pending
    run_op(2, rnd_norm(), rnd_norm(), 10, 4'b0001, d, e);
    chk("after_bp_grant", 32'(req_ready), 32'h1);
    run_op(0, rnd_norm(), rnd_norm(), 0, '0, d, e);

    // Reset in the middle of an op on requester 2 (ptr would become 3)
    req_a[2*32 +: 32] = rnd_norm();
    req_b[2*32 +: 32] = rnd_norm();
    req_valid = 4'b0100;
    #1;
    chk("mid_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '1;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_mul_b", mul_b, 0);
    chk("mid_rst_id", 32'(rsp_id), 0);
    chk("mid_rst_exc", 32'(rsp_exc), 0);
    chk("mid_rst_count", 32'(op_count), 0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_rst_no_rsp", 32'(rsp_valid), 0);
      chk("post_rst_idle", 32'(busy), 0);
    end
    req_valid = 4'b1010;
    #1;
    chk("post_rst_lowest", 32'(req_ready), 32'h2);
    run_op(1, rnd_norm(), rnd_norm(), 0, '0, d, e);

    // Round robin from ptr=0 with all requesters pending
    rst_n = 1'b0;
    tick();
    exp_cnt = 0;
    for (int i = 0; i < N; i++) begin
      ra[i] = rnd_norm();
      rb[i] = rnd_norm();
      req_a[i*32 +: 32] = ra[i];
      req_b[i*32 +: 32] = rb[i];
    end
    rst_n = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      int g;
      g = (c / 4) % N;
      #1;
      chk("rr_onehot", 32'($countones(req_ready) <= 1), 1);
      chk("rr_grant", 32'(req_ready), (c % 4 == 0) ? 32'(1 << g) : 0);
      if (c % 4 == 3) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 1);
        chk("rr_rsp_id", 32'(rsp_id), 32'(g));
        chk("rr_rsp_data", rsp_data, fmul(ra[g], rb[g]));
        exp_cnt++;
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rr_count", 32'(op_count), 32'(exp_cnt));
    chk("rr_idle", 32'(busy), 0);
    tick();

    // Random operand pairs, random requester and stall
    for (int t = 0; t < 100; t++) begin
      run_op(int'($urandom_range(0, N - 1)), rnd_norm(), rnd_norm(),
             int'($urandom_range(0, 2)), '0, d, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_mul_scheduler.md
Name: fp_mul_scheduler

Overview:
- Round-robin scheduler sharing one single-precision Multiplication datapath among N requesters.
- The multiplier samples its inputs both combinationally (exponent path) and through its internal register stage (fraction and type-check path), so operands must stay stable across the register edge.
- This block latches one request, holds the operands on the multiplier for HOLD cycles, captures the result, and returns it with the requester ID over a valid/ready response port.
- One operation is in flight at a time.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= N.
- HOLD, 2, cycles operands are held before the result is captured. Minimum 2, matching the multiplier's single register stage.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester grant/accept; one-hot or zero.
- req_a  in  32*N  operand A, IEEE-754 single; requester i occupies bits [32i+31:32i].
- req_b  in  32*N  operand B, same packing.
- mul_a  out  32  operand A to the multiplier inA.
- mul_b  out  32  operand B to the multiplier inB.
- mul_out  in  32  multiplier result out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  32  captured product.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_exc  out  3  {nan, inf, zero} classification of rsp_data.
- busy  out  1  high whenever state != IDLE.
- op_count  out  16  completed responses, wraps at 0xFFFF -> 0.

Behaviour:
- Reset: every output and register is 0. This covers state=IDLE, ptr=0, op_a, op_b, rsp_data, rsp_id, rsp_exc, cnt and op_count. Reset is asynchronous; asserting it mid-operation aborts the op silently with no response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Winner w = first i with req_valid[i] set, searching ptr, ptr+1, ... mod N.
  - req_ready[w]=1 combinationally in the same cycle; all other bits are 0.
  - At the edge: op_a<=req_a[w], op_b<=req_b[w], rsp_id<=w, ptr<=(w+1) mod N, cnt<=0, go to ISSUE.
  - With no valid request, state is unchanged and req_ready=0.
- ISSUE: req_ready=0. cnt increments each cycle. On the cycle where cnt==HOLD-1:
  - rsp_data<=mul_out.
  - rsp_exc computed from mul_out: nan = exp==0xFF and frac!=0; inf = exp==0xFF and frac==0; zero = bits[30:0]==0.
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_data, rsp_id and rsp_exc are held stable while rsp_ready=0, with unlimited stall.
  - When rsp_ready=1: op_count++ and go to IDLE.
  - No new grant occurs in the handshake cycle; earliest next grant is the following cycle.
- mul_a/mul_b are driven from op_a/op_b in all states. Values stay constant from the cycle after accept until the next accept.
- Latency: accept in cycle 0 -> rsp_valid first high in cycle HOLD+1. Peak throughput is one op per HOLD+2 cycles.
- Fairness: a requester holding req_valid is granted within N grants.
- Requester obligations: req_valid may drop without handshake, and the scheduler takes no action. Operand values are sampled only in the accept cycle.
- Simultaneous requests in IDLE resolve by ptr only. Requesters that lose keep waiting.
- rsp_ready is ignored outside RESP.
- ptr wraps N-1 -> 0. op_count wraps 0xFFFF -> 0.

Test Plan:
- Single op, HOLD=2: requester 1 sends A=0x40000000 (2.0), B=0x40400000 (3.0). Expect req_ready=0b0010 in cycle 0 and rsp_valid in cycle 3 with rsp_data=0x40C00000, rsp_id=1, rsp_exc=000, op_count=1.
- Round-robin: all 4 req_valid held high with rsp_ready=1. Grants occur in order 0,1,2,3,0. Consecutive grants are 4 cycles apart, and req_ready is never multi-hot.
- Backpressure: rsp_ready=0 for 10 cycles in RESP. rsp_data, rsp_id and rsp_exc stay constant and no req_ready is asserted. Release gives exactly one handshake, then IDLE.
- Exceptions: 0x7F800000 (Inf) x 0x00000000 yields NaN -> rsp_exc=100. 0x7F800000 x 0x3F800000 yields rsp_exc=010 with sign 0. 0x00000000 x 0xBF800000 yields rsp_exc=001 with rsp_data=0x80000000.
- Reset mid-op: assert rst_n=0 during ISSUE. All outputs are 0 immediately (asynchronously), and no rsp_valid appears after release. The next grant goes to the lowest valid index (ptr=0).
- Stability: mul_a/mul_b are checked for no change from cycle 1 through the capture cycle, across 100 random operand pairs. rsp_data matches a reference float multiply (truncation-aware model).
